// File: rtl/float_normalizer.sv
// Post-add normalizer: turns a raw adder magnitude into an IEEE-754 single, one shift decision per cycle.
// Compile-time option: FLOAT_NORM_FAST_SHIFT_EN enables up-to-4-bit left shifts per cycle.
module float_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_zero,
    output logic        out_inf
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 25;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SUM_W  = 32;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_TOP     = 8'hFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                sign_q, sign_nxt;
    logic [EXP_W-1:0]    exp_q, exp_nxt;
    logic [MANT_W-1:0]   mant_q, mant_nxt;
    logic                ready_nxt;
    logic                valid_nxt;
    logic [SUM_W-1:0]    sum_nxt;
    logic                zero_nxt;
    logic                inf_nxt;

`ifdef FLOAT_NORM_FAST_SHIFT_EN
    logic [2:0]          shift_k_c;

    // Leading zeros of mant[23:0], capped at 4; only consulted when mant[23] is clear.
    always_comb begin
        shift_k_c = 3'd4;
        if (mant_q[23])      shift_k_c = 3'd0;
        else if (mant_q[22]) shift_k_c = 3'd1;
        else if (mant_q[21]) shift_k_c = 3'd2;
        else if (mant_q[20]) shift_k_c = 3'd3;
    end
`endif

    // Next-state and next-output decision.
    always_comb begin
        state_nxt = state;
        sign_nxt  = sign_q;
        exp_nxt   = exp_q;
        mant_nxt  = mant_q;
        ready_nxt = in_ready;
        valid_nxt = out_valid;
        sum_nxt   = out_sum;
        zero_nxt  = out_zero;
        inf_nxt   = out_inf;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nxt  = in_sign;
                    exp_nxt   = in_exp;
                    mant_nxt  = in_mant;
                    ready_nxt = 1'b0;
                    state_nxt = NORM;
                end
            end

            NORM: begin
                if (exp_q == EXP_SPECIAL) begin
                    sum_nxt   = {sign_q, EXP_SPECIAL, FRAC_W'(0)};
                    zero_nxt  = 1'b0;
                    inf_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end else if (mant_q == '0) begin
                    sum_nxt   = '0;
                    zero_nxt  = 1'b1;
                    inf_nxt   = 1'b0;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end else if (mant_q[24]) begin
                    // Carry-out: renormalize right unless that overflows the exponent range.
                    if (exp_q == EXP_TOP) begin
                        sum_nxt   = {sign_q, EXP_SPECIAL, FRAC_W'(0)};
                        zero_nxt  = 1'b0;
                        inf_nxt   = 1'b1;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        mant_nxt = mant_q >> 1;
                        exp_nxt  = exp_q + EXP_W'(1);
                    end
                end else if (mant_q[23]) begin
                    sum_nxt   = {sign_q, exp_q, mant_q[FRAC_W-1:0]};
                    zero_nxt  = 1'b0;
                    inf_nxt   = 1'b0;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end else begin
`ifdef FLOAT_NORM_FAST_SHIFT_EN
                    if (exp_q <= EXP_W'(shift_k_c)) begin
                        sum_nxt   = {sign_q, (SUM_W-1)'(0)};
                        zero_nxt  = 1'b1;
                        inf_nxt   = 1'b0;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        mant_nxt = mant_q << shift_k_c;
                        exp_nxt  = exp_q - EXP_W'(shift_k_c);
                    end
`else
                    if (exp_q <= EXP_W'(1)) begin
                        sum_nxt   = {sign_q, (SUM_W-1)'(0)};
                        zero_nxt  = 1'b1;
                        inf_nxt   = 1'b0;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        mant_nxt = mant_q << 1;
                        exp_nxt  = exp_q - EXP_W'(1);
                    end
`endif
                end
            end

            HOLD: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: begin
                valid_nxt = 1'b0;
                ready_nxt = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_zero  <= 1'b0;
            out_inf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            sign_q    <= sign_nxt;
            exp_q     <= exp_nxt;
            mant_q    <= mant_nxt;
            in_ready  <= ready_nxt;
            out_valid <= valid_nxt;
            out_sum   <= sum_nxt;
            out_zero  <= zero_nxt;
            out_inf   <= inf_nxt;
        end
    end

endmodule

// File: tb/tb_float_normalizer.sv
// Scoreboard bench for float_normalizer: driver queues expected results, a monitor pops and compares.
module tb_float_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_zero;
    logic        out_inf;

`ifdef FLOAT_NORM_FAST_SHIFT_EN
    localparam int unsigned LAT_TINY   = 7;
    localparam int unsigned LAT_FLUSH3 = 1;
`else
    localparam int unsigned LAT_TINY   = 24;
    localparam int unsigned LAT_FLUSH3 = 3;
`endif

    typedef struct {
        logic [31:0] sum;
        logic        zero;
        logic        inf;
        int unsigned lat;
        int unsigned hold;
    } exp_t;

    exp_t        sb[$];
    int unsigned acc_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    float_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_zero  (out_zero),
        .out_inf   (out_inf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Waits for in_ready, presents one input for one accept edge, optionally queues its expectation.
    task automatic issue(input logic s, input logic [7:0] e, input logic [24:0] m,
                         input logic [31:0] sum, input logic z, input logic i,
                         input int unsigned lat, input int unsigned hold, input bit track);
        int unsigned w;
        exp_t t;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_valid = 1'b1;
        if (track) begin
            t.sum = sum; t.zero = z; t.inf = i; t.lat = lat; t.hold = hold;
            sb.push_back(t);
        end
        @(posedge clk);
        #1;
        if (track) acc_q.push_back(cyc);
        in_valid = 1'b0;
    endtask

    // Monitor: compares each new result, checks stability while held, drives out_ready.
    initial begin
        bit          seen;
        int unsigned held;
        int unsigned acc;
        exp_t        cur;
        seen = 1'b0;
        held = 0;
        acc  = 0;
        cur.sum = '0; cur.zero = 1'b0; cur.inf = 1'b0; cur.lat = 0; cur.hold = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen      = 1'b0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    if (sb.size() == 0 || acc_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: got %h required none", out_sum);
                        cur.sum = out_sum; cur.hold = 0;
                    end else begin
                        cur = sb.pop_front();
                        acc = acc_q.pop_front();
                        check("out_sum", out_sum, cur.sum);
                        check("out_zero", 32'(out_zero), 32'(cur.zero));
                        check("out_inf", 32'(out_inf), 32'(cur.inf));
                        check("latency", cyc - acc, cur.lat);
                    end
                    seen = 1'b1;
                    held = 0;
                end else begin
                    check("hold_sum", out_sum, cur.sum);
                    held++;
                end
                check("in_ready_busy", 32'(in_ready), 32'd0);
                out_ready = (held >= cur.hold);
            end else begin
                seen      = 1'b0;
                out_ready = 1'b0;
            end
        end
    end

    initial begin
        int unsigned w;
        bit          stale;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_exp   = '0;
        in_mant  = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_out_inf", 32'(out_inf), 32'd0);
        rst_n = 1'b1;

        //     sign  exp    mant          sum           z     i     lat         hold
        issue(1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 1,          0, 1'b1);
        issue(1'b0, 8'h7F, 25'h1000000, 32'h40000000, 1'b0, 1'b0, 2,          0, 1'b1);
        issue(1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1'b0, 1'b1, 1,          0, 1'b1);
        issue(1'b0, 8'h80, 25'h0000001, 32'h34800000, 1'b0, 1'b0, LAT_TINY,   0, 1'b1);
        issue(1'b1, 8'h03, 25'h0000001, 32'h80000000, 1'b1, 1'b0, LAT_FLUSH3, 0, 1'b1);
        issue(1'b1, 8'h55, 25'h0000000, 32'h00000000, 1'b1, 1'b0, 1,          0, 1'b1);
        issue(1'b1, 8'hFF, 25'h0C00000, 32'hFF800000, 1'b0, 1'b1, 1,          0, 1'b1);
        issue(1'b1, 8'h81, 25'h0C00000, 32'hC0C00000, 1'b0, 1'b0, 1,          3, 1'b1);
        issue(1'b0, 8'h01, 25'h0400000, 32'h00000000, 1'b1, 1'b0, 1,          0, 1'b1);
        issue(1'b0, 8'h02, 25'h0400000, 32'h00800000, 1'b0, 1'b0, 2,          0, 1'b1);
        issue(1'b0, 8'h10, 25'h1FFFFFF, 32'h08FFFFFF, 1'b0, 1'b0, 2,          0, 1'b1);

        // Abort a long normalization with reset; nothing may come out afterwards.
        issue(1'b0, 8'h80, 25'h0000001, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_sum", out_sum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("abort_no_stale", 32'(stale), 32'd0);
        check("abort_idle_ready", 32'(in_ready), 32'd1);
        issue(1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 1, 0, 1'b1);

        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
